// File: rtl/rps_pkg.sv
// Shared types and ASCII event codes for the stone/paper/scissors match engine.
package rps_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TIE = 2'd0,
        P1  = 2'd1,
        P2  = 2'd2
    } round_t;

    localparam logic [7:0] EV_NONE       = 8'h00;
    localparam logic [7:0] EV_TIE        = 8'h30;
    localparam logic [7:0] EV_P1_ROUND   = 8'h31;
    localparam logic [7:0] EV_P2_ROUND   = 8'h32;
    localparam logic [7:0] EV_INVALID    = 8'h3F;
    localparam logic [7:0] EV_P1_MATCH   = 8'h41;
    localparam logic [7:0] EV_P2_MATCH   = 8'h42;
    localparam logic [7:0] EV_P1_FORFEIT = 8'h61;
    localparam logic [7:0] EV_P2_FORFEIT = 8'h62;

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge: move m beats n iff (m - n) mod NUM_MOVES is odd.
// Both moves are assumed already validated (< NUM_MOVES).
module rps_round_judge
    import rps_pkg::*;
#(
    parameter int NUM_MOVES = 3
) (
    input  logic [2:0] p1_move,
    input  logic [2:0] p2_move,
    output round_t     result
);

    localparam logic [3:0] MOVES = 4'(NUM_MOVES);

    logic [3:0] raw_diff;
    logic [3:0] diff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        raw_diff = {1'b0, p1_move} + MOVES - {1'b0, p2_move};
        diff     = raw_diff;
        if (raw_diff >= MOVES) begin
            diff = raw_diff - MOVES;
        end
        result = TIE;
        if (p1_move != p2_move) begin
            result = diff[0] ? P1 : P2;
        end
    end

endmodule

// File: rtl/tt_um_rps_match_engine.sv
// Best-of-N stone/paper/scissors match engine (Tiny Tapeout tile).
// Define RPS_TIMEOUT_EN to enable the one-sided-lock forfeit timer.
module tt_um_rps_match_engine
    import rps_pkg::*;
#(
    parameter int NUM_MOVES      = 3,
    parameter int ROUNDS_TO_WIN  = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] WIN_SCORE = 3'(ROUNDS_TO_WIN);
    localparam logic [2:0] MOVES     = 3'(NUM_MOVES);

    state_t     state, state_next;
    logic [2:0] p1_score, p1_score_next, p2_score, p2_score_next;
    logic       p1_locked, p1_locked_next, p2_locked, p2_locked_next;
    logic [2:0] p1_move, p1_move_next, p2_move, p2_move_next;
    logic       p1_hist, p2_hist;
    logic [7:0] event_code, event_code_next;
    logic       match_over, match_over_next;

    logic       p1_event, p2_event, new_match;
    logic       award, award_forfeit;
    round_t     award_who, judged;

`ifdef RPS_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer, timer_next;
    logic               unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:1]};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:1], (TIMEOUT_CYCLES != 0)};
`endif

    assign p1_event  = ui_in[6] & ~p1_hist;
    assign p2_event  = ui_in[7] & ~p2_hist;
    assign new_match = uio_in[0];

    rps_round_judge #(.NUM_MOVES(NUM_MOVES)) u_judge (
        .p1_move (p1_move),
        .p2_move (p2_move),
        .result  (judged)
    );

    always_comb begin
        state_next      = state;
        p1_score_next   = p1_score;
        p2_score_next   = p2_score;
        p1_locked_next  = p1_locked;
        p2_locked_next  = p2_locked;
        p1_move_next    = p1_move;
        p2_move_next    = p2_move;
        event_code_next = event_code;
        match_over_next = match_over;
        award           = 1'b0;
        award_forfeit   = 1'b0;
        award_who       = TIE;
`ifdef RPS_TIMEOUT_EN
        timer_next      = '0;
`endif

        if (new_match) begin
            state_next      = COLLECT;
            p1_score_next   = '0;
            p2_score_next   = '0;
            p1_locked_next  = 1'b0;
            p2_locked_next  = 1'b0;
            event_code_next = EV_NONE;
            match_over_next = 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if ((p1_event && !p1_locked && ui_in[2:0] >= MOVES) ||
                        (p2_event && !p2_locked && ui_in[5:3] >= MOVES)) begin
                        event_code_next = EV_INVALID;
                    end
                    if (p1_event && !p1_locked && ui_in[2:0] < MOVES) begin
                        p1_locked_next = 1'b1;
                        p1_move_next   = ui_in[2:0];
                    end
                    if (p2_event && !p2_locked && ui_in[5:3] < MOVES) begin
                        p2_locked_next = 1'b1;
                        p2_move_next   = ui_in[5:3];
                    end
                    if (p1_locked_next && p2_locked_next) begin
                        state_next = RESOLVE;
                    end
`ifdef RPS_TIMEOUT_EN
                    // One player waiting alone: count towards the forfeit.
                    else if (p1_locked ^ p2_locked) begin
                        if (timer == TIMER_LAST) begin
                            award         = 1'b1;
                            award_forfeit = 1'b1;
                            award_who     = p1_locked ? P1 : P2;
                        end else begin
                            timer_next = timer + 1'b1;
                        end
                    end
`endif
                end
                RESOLVE: begin
                    award     = 1'b1;
                    award_who = judged;
                end
                DONE: begin
                end
                default: state_next = COLLECT;
            endcase

            if (award) begin
                p1_locked_next = 1'b0;
                p2_locked_next = 1'b0;
                state_next     = COLLECT;
                unique case (award_who)
                    P1: begin
                        p1_score_next   = p1_score + 3'd1;
                        event_code_next = award_forfeit ? EV_P1_FORFEIT : EV_P1_ROUND;
                        if (p1_score_next == WIN_SCORE) begin
                            event_code_next = EV_P1_MATCH;
                            match_over_next = 1'b1;
                            state_next      = DONE;
                        end
                    end
                    P2: begin
                        p2_score_next   = p2_score + 3'd1;
                        event_code_next = award_forfeit ? EV_P2_FORFEIT : EV_P2_ROUND;
                        if (p2_score_next == WIN_SCORE) begin
                            event_code_next = EV_P2_MATCH;
                            match_over_next = 1'b1;
                            state_next      = DONE;
                        end
                    end
                    default: event_code_next = EV_TIE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            p1_score   <= '0;
            p2_score   <= '0;
            p1_locked  <= 1'b0;
            p2_locked  <= 1'b0;
            p1_move    <= '0;
            p2_move    <= '0;
            p1_hist    <= 1'b0;
            p2_hist    <= 1'b0;
            event_code <= EV_NONE;
            match_over <= 1'b0;
`ifdef RPS_TIMEOUT_EN
            timer      <= '0;
`endif
        end else if (ena) begin
            state      <= state_next;
            p1_score   <= p1_score_next;
            p2_score   <= p2_score_next;
            p1_locked  <= p1_locked_next;
            p2_locked  <= p2_locked_next;
            p1_move    <= p1_move_next;
            p2_move    <= p2_move_next;
            p1_hist    <= ui_in[6];
            p2_hist    <= ui_in[7];
            event_code <= event_code_next;
            match_over <= match_over_next;
`ifdef RPS_TIMEOUT_EN
            timer      <= timer_next;
`endif
        end
    end

    assign uo_out  = event_code;
    assign uio_out = {match_over, p2_score, p1_score, 1'b0};
    assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_um_rps_match_engine.sv
// Scoreboard bench for tt_um_rps_match_engine: directed scenarios then random play,
// checked against a rule-level match model. Honours RPS_TIMEOUT_EN if defined.
module tb_tt_um_rps_match_engine;

    localparam int NUM_MOVES = 3;
    localparam int ROUNDS    = 3;
    localparam int TMO       = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_q[$];

    // Reference model state
    bit         f1, f2, pend, over, h1, h2;
    int         mv1, mv2, s1, s2, tmr;
    logic [7:0] muo;

    tt_um_rps_match_engine #(
        .NUM_MOVES      (NUM_MOVES),
        .ROUNDS_TO_WIN  (ROUNDS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got uo/uio=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int judge(input int a, input int b);
        int d;
        if (a == b) return 0;
        d = ((a - b) % NUM_MOVES + NUM_MOVES) % NUM_MOVES;
        return (d % 2 == 1) ? 1 : 2;
    endfunction

    function automatic logic [7:0] model_uio();
        logic [2:0] a, b;
        a = 3'(s1);
        b = 3'(s2);
        return {over, b, a, 1'b0};
    endfunction

    task automatic model_clear();
        f1 = 0; f2 = 0; pend = 0; over = 0;
        s1 = 0; s2 = 0; tmr = 0; muo = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] ui, input logic nm, input logic en);
        bit e1, e2, o1, o2, fo;
        int w;
        if (!rst_n) begin
            model_clear();
            h1 = 0; h2 = 0; mv1 = 0; mv2 = 0;
            return;
        end
        if (!en) return;
        e1 = ui[6] && !h1;
        e2 = ui[7] && !h2;
        h1 = ui[6];
        h2 = ui[7];
        if (nm) begin
            model_clear();
            return;
        end
        w  = -1;
        fo = 0;
        if (pend) begin
            pend = 0;
            w = judge(mv1, mv2);
        end else if (!over) begin
            o1 = f1;
            o2 = f2;
            if (e1 && !f1) begin
                if (int'(ui[2:0]) < NUM_MOVES) begin f1 = 1; mv1 = int'(ui[2:0]); end
                else muo = 8'h3F;
            end
            if (e2 && !f2) begin
                if (int'(ui[5:3]) < NUM_MOVES) begin f2 = 1; mv2 = int'(ui[5:3]); end
                else muo = 8'h3F;
            end
            if (f1 && f2) begin
                pend = 1;
                tmr  = 0;
            end else if (o1 != o2) begin
`ifdef RPS_TIMEOUT_EN
                tmr++;
                if (tmr == TMO) begin
                    w  = o1 ? 1 : 2;
                    fo = 1;
                end
`endif
            end else begin
                tmr = 0;
            end
        end
        if (w >= 0) begin
            f1 = 0; f2 = 0; tmr = 0;
            if (w == 0) begin
                muo = 8'h30;
            end else if (w == 1) begin
                s1++;
                muo = fo ? 8'h61 : 8'h31;
                if (s1 == ROUNDS) begin muo = 8'h41; over = 1; end
            end else begin
                s2++;
                muo = fo ? 8'h62 : 8'h32;
                if (s2 == ROUNDS) begin muo = 8'h42; over = 1; end
            end
        end
    endtask

    // Drive at the falling edge, let the model follow the rising edge, return at the next falling edge.
    task automatic step(input logic [7:0] ui, input logic nm, input logic en);
        ui_in  = ui;
        uio_in = {7'h00, nm};
        ena    = en;
        @(posedge clk);
        model_step(ui, nm, en);
        sb_q.push_back({muo, model_uio()});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic expect_now(input string name, input logic [15:0] exp);
        #1;
        check(name, {uo_out, uio_out}, exp);
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [15:0] exp_v;
            exp_v = sb_q.pop_front();
            check("scoreboard", {uo_out, uio_out}, exp_v);
        end
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        h1 = 0; h2 = 0; mv1 = 0; mv2 = 0;
        model_clear();
        repeat (3) @(negedge clk);
        expect_now("reset_outputs", 16'h0000);
        check("uio_oe", {8'h00, uio_oe}, 16'h00FE);
        rst_n = 1'b1;
        @(negedge clk);

        idle(20);
        expect_now("idle_unchanged", 16'h0000);

        // P1 paper locks, P2 stone locks three cycles later
        step(8'h41, 1'b0, 1'b1);
        idle(2);
        step(8'h80, 1'b0, 1'b1);
        idle(1);
        expect_now("p1_round", 16'h3102);

        // Same-edge scissors vs scissors
        step(8'hD2, 1'b0, 1'b1);
        idle(1);
        expect_now("tie_round", 16'h3002);

        // Invalid move, valid re-lock, ignored re-lock
        step(8'h43, 1'b0, 1'b1);
        idle(1);
        expect_now("invalid_move", 16'h3F02);
        step(8'h42, 1'b0, 1'b1);
        idle(1);
        step(8'h40, 1'b0, 1'b1);
        idle(1);
        step(8'h80, 1'b0, 1'b1);
        idle(1);
        expect_now("relock_ignored", 16'h3212);

        // P2 paper beats P1 stone twice more to take the match
        step(8'hC8, 1'b0, 1'b1);
        idle(1);
        step(8'hC8, 1'b0, 1'b1);
        idle(1);
        expect_now("p2_match", 16'h42B2);
        step(8'hC8, 1'b0, 1'b1);
        idle(2);
        expect_now("done_holds", 16'h42B2);
        step(8'h00, 1'b1, 1'b1);
        idle(1);
        expect_now("new_match", 16'h0000);

        // One-sided lock
        step(8'h41, 1'b0, 1'b1);
`ifdef RPS_TIMEOUT_EN
        idle(TMO);
        expect_now("forfeit", 16'h6102);
`else
        idle(100);
        expect_now("no_timeout", 16'h0000);
`endif
        step(8'h00, 1'b1, 1'b1);
        idle(1);

        // Async reset while a round is being resolved
        step(8'hC8, 1'b0, 1'b1);
        idle(1);
        expect_now("pre_reset_round", 16'h3210);
        step(8'hC8, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        expect_now("reset_in_resolve", 16'h0000);
        step(8'h00, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Lock held high across ena low is not a new event
        step(8'h41, 1'b0, 1'b1);
        step(8'h41, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h41, 1'b0, 1'b0);
        step(8'h41, 1'b0, 1'b1);
        step(8'h41, 1'b0, 1'b1);
        step(8'hC1, 1'b0, 1'b1);
        step(8'hC1, 1'b0, 1'b1);
        expect_now("held_lock_no_event", 16'h0000);
        step(8'h00, 1'b1, 1'b1);
        idle(1);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ui;
            logic       nm, en;
            ui[2:0] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ui[5:3] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ui[6]   = ($urandom_range(0, 99) < 35);
            ui[7]   = ($urandom_range(0, 99) < 35);
            nm      = ($urandom_range(0, 99) < 2);
            en      = ($urandom_range(0, 99) < 90);
            step(ui, nm, en);
        end

        #20;
        check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
